// File: rtl/hamming_encoder_tx_if.sv
// hamming_encoder_tx_if: word handshake, parallel codeword strobe and serial frame bundle
interface hamming_encoder_tx_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [2:0]       err_inj_pos;
  logic             code_valid;
  logic [6:0]       code;
  logic             ser_out;
  logic             ser_frame;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;
  modport master (
    output in_valid, in_data, err_inj_pos,
    input  in_ready, code_valid, code, ser_out, ser_frame, ser_last, busy, frames_sent
  );
  modport slave (
    input  in_valid, in_data, err_inj_pos,
    output in_ready, code_valid, code, ser_out, ser_frame, ser_last, busy, frames_sent
  );
endinterface

// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx: Hamming(7,4) encoder with one-word hold buffer and framed serial output
module hamming_encoder_tx #(
  parameter bit SER_LSB_FIRST = 1'b1,
  parameter int CNT_W         = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hamming_encoder_tx_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [6:0]       shift_q, shift_d, hold_q, hold_d, code_q, code_d;
  logic             hold_full_q, hold_full_d, cv_q, cv_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [6:0]       enc, inj, ld_word;
  logic [3:0]       d;
  logic             accept, last, ld;
  always_comb begin
    d = bus.in_data;
    inj = (bus.err_inj_pos != 3'd0) ? (7'd1 << (bus.err_inj_pos - 3'd1)) : 7'd0;
    enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]} ^ inj;
    accept = bus.in_valid && !hold_full_q;
    last = (state_q == SHIFT) && (cnt_q == 3'd6);
    // a held word always wins over a new one at a frame boundary
    ld = ((state_q == IDLE) || last) && (hold_full_q || accept);
    ld_word = hold_full_q ? hold_q : enc;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    code_d = code_q;
    cv_d = 1'b0;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    frames_d = frames_q + CNT_W'(last);
    if (ld) begin
      state_d = SHIFT;
      cnt_d = 3'd0;
      shift_d = ld_word;
      code_d = ld_word;
      cv_d = 1'b1;
    end else if (last) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q + 3'd1;
    end
    if ((state_q == SHIFT) && !last && accept) begin
      hold_d = enc;
      hold_full_d = 1'b1;
    end else if (last && hold_full_q) begin
      hold_full_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      shift_q <= 7'd0;
      code_q <= 7'd0;
      cv_q <= 1'b0;
      hold_q <= 7'd0;
      hold_full_q <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      code_q <= code_d;
      cv_q <= cv_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      frames_q <= frames_d;
    end
  end
  assign bus.in_ready = !hold_full_q;
  assign bus.code_valid = cv_q;
  assign bus.code = code_q;
  assign bus.ser_frame = (state_q == SHIFT);
  assign bus.ser_out = (state_q == SHIFT) && (SER_LSB_FIRST ? shift_q[cnt_q] : shift_q[3'd6 - cnt_q]);
  assign bus.ser_last = last;
  assign bus.busy = (state_q == SHIFT) || hold_full_q;
  assign bus.frames_sent = frames_q;
endmodule

// File: tb/tb_hamming_encoder_tx.sv
// tb_hamming_encoder_tx: directed timing checks plus randomized scoreboard against a Hamming model
module tb_hamming_encoder_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hamming_encoder_tx_if #(.CNT_W(16)) ifa ();
  hamming_encoder_tx_if #(.CNT_W(16)) ifb ();
  hamming_encoder_tx #(.SER_LSB_FIRST(1'b1), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  hamming_encoder_tx #(.SER_LSB_FIRST(1'b0), .CNT_W(16)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(ifb));
  assign ifb.in_valid = ifa.in_valid;
  assign ifb.in_data = ifa.in_data;
  assign ifb.err_inj_pos = ifa.err_inj_pos;
  int vectors = 0, miscompares = 0, nf = 0, bidx = 0;
  int fc, first, lst, lowc, wi, acc_cnt;
  bit mon_en = 1'b0;
  logic [6:0] q_code[$], q_ser[$];
  logic [6:0] acc, w[3];
  logic [3:0] rd;
  logic [2:0] rp;
  logic rv;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // codeword by position: data at 3,5,6,7; parity at 2^j covers positions with bit j set
  function automatic logic [6:0] model(logic [3:0] dd, logic [2:0] pos);
    logic [7:1] cw;
    cw = '0;
    cw[3] = dd[0];
    cw[5] = dd[1];
    cw[6] = dd[2];
    cw[7] = dd[3];
    for (int j = 0; j < 3; j++)
      for (int q = 3; q <= 7; q++)
        if (q != (1 << j) && ((q >> j) & 1) == 1) cw[1 << j] ^= cw[q];
    if (pos != 3'd0) cw[pos] = ~cw[pos];
    return cw;
  endfunction
  task automatic drive(logic v, logic [3:0] dd, logic [2:0] p);
    ifa.in_valid = v;
    ifa.in_data = dd;
    ifa.err_inj_pos = p;
  endtask
  task automatic check_reset();
    check("rst_in_ready", ifa.in_ready, 1);
    check("rst_code_valid", ifa.code_valid, 0);
    check("rst_code", ifa.code, 0);
    check("rst_ser_out", ifa.ser_out, 0);
    check("rst_ser_out_msb", ifb.ser_out, 0);
    check("rst_ser_frame", ifa.ser_frame, 0);
    check("rst_ser_last", ifa.ser_last, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_frames", ifa.frames_sent, 0);
  endtask
  task automatic send_one(logic [3:0] dd, logic [2:0] p, logic [6:0] exp);
    drive(1'b1, dd, p);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0);
    check("code_valid", ifa.code_valid, 1);
    check("code", ifa.code, exp);
    for (int k = 0; k < 7; k++) begin
      check("ser_frame", ifa.ser_frame, 1);
      check("ser_lsb", ifa.ser_out, exp[k]);
      check("ser_msb", ifb.ser_out, exp[6-k]);
      check("ser_last", ifa.ser_last, (k == 6) ? 1 : 0);
      if (k == 1) check("code_valid_pulse", ifa.code_valid, 0);
      @(negedge clk);
    end
    nf++;
    check("frame_end", ifa.ser_frame, 0);
    check("frames_sent", ifa.frames_sent, nf);
  endtask
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("busy", ifa.busy, (ifa.ser_frame || !ifa.in_ready) ? 1 : 0);
      if (ifa.code_valid) begin
        if (q_code.size() == 0) check("code_extra", ifa.code_valid, 0);
        else check("sb_code", ifa.code, q_code.pop_front());
      end
      if (ifa.ser_frame) begin
        if (bidx < 7) acc[bidx] = ifa.ser_out;
        bidx++;
        if (ifa.ser_last) begin
          check("sb_ser_len", bidx, 7);
          if (q_ser.size() == 0) check("ser_extra", ifa.ser_last, 0);
          else check("sb_ser", acc, q_ser.pop_front());
          bidx = 0;
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    drive(1'b0, 4'd0, 3'd0);
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    @(negedge clk);
    send_one(4'b0111, 3'd0, 7'h34);
    send_one(4'b0000, 3'd0, 7'h00);
    send_one(4'b1111, 3'd0, 7'h7F);
    send_one(4'b1011, 3'd0, 7'h55);
    for (int dd = 0; dd < 16; dd++) send_one(4'(dd), 3'd0, model(4'(dd), 3'd0));
    for (int p = 1; p <= 7; p++) send_one(4'b1011, 3'(p), 7'h55 ^ (7'd1 << (p - 1)));
    send_one(4'b1011, 3'd3, 7'h51);
    // back-to-back: three words with in_valid held high
    for (int i = 0; i < 3; i++) w[i] = 7'($urandom);
    mon_en = 1'b1;
    bidx = 0;
    wi = 0; fc = 0; first = -1; lst = -1; lowc = 0;
    for (int c = 0; c < 40; c++) begin
      if (wi < 3) begin
        drive(1'b1, w[wi][3:0], 3'd0);
        if (ifa.in_ready) begin
          q_code.push_back(model(w[wi][3:0], 3'd0));
          q_ser.push_back(model(w[wi][3:0], 3'd0));
          wi++;
        end
      end else drive(1'b0, 4'd0, 3'd0);
      @(negedge clk);
      if (ifa.ser_frame) begin
        fc++;
        if (first < 0) first = c;
        lst = c;
      end
      if (!ifa.in_ready) lowc++;
    end
    nf += 3;
    check("b2b_frame_cycles", fc, 21);
    check("b2b_contiguous", lst - first + 1, 21);
    check("b2b_ready_low", lowc, 12);
    check("b2b_frames_sent", ifa.frames_sent, nf);
    check("b2b_q_left", q_ser.size(), 0);
    // randomized traffic with random injection
    acc_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom_range(0, 3) != 0);
      rd = 4'($urandom);
      rp = 3'($urandom_range(0, 7));
      drive(rv, rd, rp);
      if (rv && ifa.in_ready) begin
        q_code.push_back(model(rd, rp));
        q_ser.push_back(model(rd, rp));
        acc_cnt++;
      end
      @(negedge clk);
    end
    drive(1'b0, 4'd0, 3'd0);
    repeat (20) @(negedge clk);
    nf += acc_cnt;
    check("rand_frames_sent", ifa.frames_sent, nf);
    check("rand_code_left", q_code.size(), 0);
    check("rand_ser_left", q_ser.size(), 0);
    check("rand_busy_idle", ifa.busy, 0);
    mon_en = 1'b0;
    // reset mid-frame with a word held
    drive(1'b1, 4'b1100, 3'd0);
    @(negedge clk);
    drive(1'b1, 4'b0011, 3'd5);
    @(negedge clk);
    drive(1'b0, 4'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_frame_active", ifa.ser_frame, 1);
    check("mid_hold_full", ifa.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    nf = 0;
    @(negedge clk);
    check_reset();
    send_one(4'b0111, 3'd0, 7'h34);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
